// File: rtl/pipelined_addsub.sv
// Pipelined N-bit add/sub, one CHUNK-bit carry slice per stage.
// Valid/ready stream with optional signed saturation.
module pipelined_addsub #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         sat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         co,
  output logic         ovf
);

  localparam int STAGES = N / CHUNK;

  localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINN = {1'b1, {(N-1){1'b0}}};

  if (N % CHUNK != 0) begin : g_bad_chunk
    $error("N must be a multiple of CHUNK");
  end

  logic           w_en;
  logic [N-1:0]   w_bs;
  logic [N-1:0]   w_sum;
  logic           w_ovf;
  logic           w_unused;

  logic [CHUNK:0] w_add  [STAGES];
  logic [N-1:0]   w_nsum [STAGES];

  logic           r_vld  [STAGES];
  logic [N-1:0]   r_a    [STAGES];
  logic [N-1:0]   r_b    [STAGES];
  logic [N-1:0]   r_sum  [STAGES];
  logic           r_cy   [STAGES];
  logic           r_sat  [STAGES];
  logic           r_sa   [STAGES];
  logic           r_sb   [STAGES];

  assign w_en     = !r_vld[STAGES-1] || out_ready;
  assign in_ready = w_en;
  assign w_bs     = sub ? ~b : b;

  // Per-slice ripple adders and the partial sums they extend
  always_comb begin
    w_add[0] = {1'b0, a[CHUNK-1:0]}
             + {1'b0, w_bs[CHUNK-1:0]}
             + {{CHUNK{1'b0}}, sub};
    w_nsum[0] = '0;
    w_nsum[0][CHUNK-1:0] = w_add[0][CHUNK-1:0];
    for (int k = 1; k < STAGES; k++) begin
      w_add[k] = {1'b0, r_a[k-1][k*CHUNK +: CHUNK]}
               + {1'b0, r_b[k-1][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, r_cy[k-1]};
      w_nsum[k] = r_sum[k-1];
      w_nsum[k][k*CHUNK +: CHUNK] = w_add[k][CHUNK-1:0];
    end
  end

  // Shift every stage together whenever the output can advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_cy[k]  <= 1'b0;
        r_sat[k] <= 1'b0;
        r_sa[k]  <= 1'b0;
        r_sb[k]  <= 1'b0;
      end
    end else if (w_en) begin
      r_vld[0] <= in_valid;
      r_a[0]   <= a;
      r_b[0]   <= w_bs;
      r_sum[0] <= w_nsum[0];
      r_cy[0]  <= w_add[0][CHUNK];
      r_sat[0] <= sat;
      r_sa[0]  <= a[N-1];
      r_sb[0]  <= w_bs[N-1];
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_a[k]   <= r_a[k-1];
        r_b[k]   <= r_b[k-1];
        r_sum[k] <= w_nsum[k];
        r_cy[k]  <= w_add[k][CHUNK];
        r_sat[k] <= r_sat[k-1];
        r_sa[k]  <= r_sa[k-1];
        r_sb[k]  <= r_sb[k-1];
      end
    end
  end

  assign w_sum = r_sum[STAGES-1];
  assign w_ovf = (r_sa[STAGES-1] == r_sb[STAGES-1])
              && (w_sum[N-1] != r_sa[STAGES-1]);

  // Overflow flag and saturation from the final-stage registers
  always_comb begin
    result = w_sum;
    if (r_sat[STAGES-1] && w_ovf) begin
      result = r_sa[STAGES-1] ? MINN : MAXP;
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign co        = r_cy[STAGES-1];
  assign ovf       = w_ovf;

  assign w_unused = ^{r_a[STAGES-1], r_b[STAGES-1]};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed corner cases, reset
// mid-stream, backpressure and random traffic vs a model.
module tb_pipelined_addsub;

  localparam int N      = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = N / CHUNK;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          sub;
  logic          sat;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  result;
  logic          co;
  logic          ovf;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int n_out  = 0;
  bit lat_en = 1'b0;

  logic [33:0] send_q[$];
  logic [17:0] dir_q[$];
  logic [17:0] exp_q[$];
  int          acc_q[$];

  pipelined_addsub #(.N(N), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .co        (co),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Returns {co, ovf, result} from plain integer arithmetic
  function automatic logic [17:0] model(
    input logic [15:0] x, input logic [15:0] y,
    input logic s, input logic t);
    int sx, sy, r, ux, uy;
    logic c, o;
    logic [15:0] res;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    r  = s ? sx - sy : sx + sy;
    o  = (r > 32767) || (r < -32768);
    c  = s ? (ux >= uy) : (ux + uy > 65535);
    res = r[15:0];
    if (t && o) res = (r > 0) ? 16'h7FFF : 16'h8000;
    return {c, o, res};
  endfunction

  task automatic step(input logic ordy);
    logic [33:0] bt;
    @(negedge clk);
    if (send_q.size() > 0) begin
      bt = send_q[0];
      in_valid = 1'b1;
      sub = bt[33];
      sat = bt[32];
      a   = bt[31:16];
      b   = bt[15:0];
    end else begin
      in_valid = 1'b0;
    end
    out_ready = ordy;
    #1;
    chk("rdy_rule", 32'(in_ready),
        32'(!(out_valid && !out_ready)));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 0);
      end else begin
        chk("result", 32'(result), 32'(exp_q[0][15:0]));
        chk("co", 32'(co), 32'(exp_q[0][17]));
        chk("ovf", 32'(ovf), 32'(exp_q[0][16]));
        if (out_ready) begin
          if (lat_en)
            chk("latency", cyc - acc_q[0], STAGES);
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          n_out++;
        end
      end
    end
    if (in_valid && in_ready) begin
      if (dir_q.size() > 0) exp_q.push_back(dir_q.pop_front());
      else exp_q.push_back(model(a, b, sub, sat));
      acc_q.push_back(cyc);
      void'(send_q.pop_front());
    end
    cyc++;
  endtask

  task automatic drain(input int maxs);
    int k = 0;
    while ((send_q.size() > 0 || exp_q.size() > 0) && k < maxs) begin
      step(1'b1);
      k++;
    end
    chk("drain_timeout", send_q.size() + exp_q.size(), 0);
  endtask

  task automatic directed(input logic [15:0] x, input logic [15:0] y,
                          input logic s, input logic t,
                          input logic [17:0] e);
    send_q.push_back({s, t, x, y});
    dir_q.push_back(e);
    drain(20);
  endtask

  function automatic logic [33:0] rnd_beat();
    logic [15:0] x, y;
    logic s, t;
    x = 16'($urandom);
    y = 16'($urandom);
    s = 1'($urandom);
    t = 1'($urandom);
    return {s, t, x, y};
  endfunction

  initial begin
    int j;
    bit stall;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_co", 32'(co), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    lat_en = 1'b1;
    directed(16'h1234, 16'h0FFF, 0, 0, {1'b0, 1'b0, 16'h2233});
    directed(16'hFFFF, 16'h0001, 0, 0, {1'b1, 1'b0, 16'h0000});
    directed(16'h0005, 16'h0007, 1, 0, {1'b0, 1'b0, 16'hFFFE});
    directed(16'h0007, 16'h0005, 1, 0, {1'b1, 1'b0, 16'h0002});
    directed(16'h7FFF, 16'h0001, 0, 0, {1'b0, 1'b1, 16'h8000});
    directed(16'h7FFF, 16'h0001, 0, 1, {1'b0, 1'b1, 16'h7FFF});
    directed(16'h8000, 16'h0001, 1, 1, {1'b1, 1'b1, 16'h8000});
    lat_en = 1'b0;

    // Reset with one beat at the output and three in flight
    for (int i = 0; i < 4; i++) send_q.push_back(rnd_beat());
    for (int i = 0; i < 4; i++) step(1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_result", 32'(result), 0);
    chk("mid_rst_co", 32'(co), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    send_q.delete();
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      chk("stale_valid", 32'(out_valid), 0);
    end

    // Eight back-to-back beats with a three-cycle stall
    n_out = 0;
    for (int i = 0; i < 8; i++) send_q.push_back(rnd_beat());
    j = 0;
    while ((send_q.size() > 0 || exp_q.size() > 0) && j < 60) begin
      stall = (j >= 6 && j < 9);
      step(!stall);
      chk("in_ready_stream", 32'(in_ready), stall ? 0 : 1);
      j++;
    end
    chk("stream_count", n_out, 8);

    // Random traffic with random backpressure
    n_out = 0;
    for (int i = 0; i < 40; i++) send_q.push_back(rnd_beat());
    j = 0;
    while ((send_q.size() > 0 || exp_q.size() > 0) && j < 400) begin
      step(1'($urandom_range(0, 3) != 0));
      j++;
    end
    chk("random_count", n_out, 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
